// File: rtl/fir_ntap_approx.sv
`default_nettype none
// ============================================================================
// Module   : fir_ntap_approx
// Purpose  : Run-time programmable N-tap direct-form FIR with valid handshake
//            and a per-sample approximate-product (LSB truncation) mode.
// Revision : 1.0 - initial release
// ============================================================================
module fir_ntap_approx #(
    parameter int DW         = 16,
    parameter int CW         = 16,
    parameter int NTAPS      = 8,
    parameter int SHIFT      = 15,
    parameter int APPROX_LSB = 0,
    parameter int AW         = $clog2(NTAPS)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] x,
    input  logic                 approx_en,
    output logic                 out_valid,
    output logic signed [DW-1:0] y
);

    localparam int PW   = DW + CW;
    localparam int ACCW = PW + $clog2(NTAPS);
    localparam logic [PW-1:0] C_APPROX_MASK = {PW{1'b1}} << APPROX_LSB;

    logic signed [DW-1:0] d_q [NTAPS];
    logic signed [DW-1:0] d_d [NTAPS];
    logic signed [CW-1:0] h_q [NTAPS];
    logic signed [CW-1:0] h_d [NTAPS];
    logic [PW-1:0]        p_q [NTAPS];
    logic [PW-1:0]        p_d [NTAPS];
    logic                 v1_q, v1_d;
    logic                 ap_q, ap_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                 v2_q, v2_d;
    logic signed [DW-1:0] y_q, y_d;
    logic                 out_valid_q, out_valid_d;

    logic                 w_accept;
    logic [PW-1:0]        w_pm;
    logic signed [ACCW-1:0] w_shifted;
    logic [ACCW-DW:0]     w_upper;
    logic signed [DW-1:0] w_sat;

    // Delay line and coefficient bank; products below read the old h_q so a
    // write landing on the same edge as a sample only affects later samples.
    always_comb begin
        w_accept = in_valid & ~clear;
        for (int k = 0; k < NTAPS; k++) begin
            d_d[k] = d_q[k];
            h_d[k] = h_q[k];
        end
        if (clear) begin
            for (int k = 0; k < NTAPS; k++) begin
                d_d[k] = '0;
            end
        end else if (in_valid) begin
            d_d[0] = x;
            for (int k = 1; k < NTAPS; k++) begin
                d_d[k] = d_q[k-1];
            end
        end
        if (coef_we && (int'(coef_addr) < NTAPS)) begin
            h_d[coef_addr] = coef_data;
        end
    end

    // Stage 1: full-width products of the updated delay line.
    always_comb begin
        v1_d = w_accept;
        ap_d = ap_q;
        for (int k = 0; k < NTAPS; k++) begin
            p_d[k] = p_q[k];
        end
        if (w_accept) begin
            ap_d = approx_en;
            for (int k = 0; k < NTAPS; k++) begin
                p_d[k] = {{CW{d_d[k][DW-1]}}, d_d[k]} * {{DW{h_q[k][CW-1]}}, h_q[k]};
            end
        end
    end

    // Stage 2: masked products summed with enough guard bits to never overflow.
    always_comb begin
        v2_d  = v1_q & ~clear;
        acc_d = acc_q;
        w_pm  = '0;
        if (v1_q) begin
            acc_d = '0;
            for (int k = 0; k < NTAPS; k++) begin
                w_pm  = ap_q ? (p_q[k] & C_APPROX_MASK) : p_q[k];
                acc_d = acc_d + {{(ACCW-PW){w_pm[PW-1]}}, w_pm};
            end
        end
    end

    // Stage 3: Q-format scaling and saturation to the output width.
    always_comb begin
        w_shifted = acc_q >>> SHIFT;
        w_upper   = w_shifted[ACCW-1:DW-1];
        if ((&w_upper) || !(|w_upper)) begin
            w_sat = w_shifted[DW-1:0];
        end else if (w_shifted[ACCW-1]) begin
            w_sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            w_sat = {1'b0, {(DW-1){1'b1}}};
        end
        out_valid_d = v2_q;
        y_d         = v2_q ? w_sat : y_q;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < NTAPS; k++) begin
                d_q[k] <= '0;
                h_q[k] <= '0;
                p_q[k] <= '0;
            end
            v1_q        <= 1'b0;
            ap_q        <= 1'b0;
            acc_q       <= '0;
            v2_q        <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                d_q[k] <= d_d[k];
                h_q[k] <= h_d[k];
                p_q[k] <= p_d[k];
            end
            v1_q        <= v1_d;
            ap_q        <= ap_d;
            acc_q       <= acc_d;
            v2_q        <= v2_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_ntap_approx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_ntap_approx
// Purpose  : Directed self-checking bench; instance 0 is 8 taps / SHIFT 15,
//            instance 1 is 5 taps / SHIFT 0 / APPROX_LSB 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_ntap_approx;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic               coef_we   [2];
    logic [2:0]         coef_addr [2];
    logic signed [15:0] coef_data [2];
    logic               clear     [2];
    logic               in_valid  [2];
    logic signed [15:0] x         [2];
    logic               approx_en [2];
    logic               out_valid [2];
    logic signed [15:0] y         [2];

    fir_ntap_approx #(.DW(16), .CW(16), .NTAPS(8), .SHIFT(15), .APPROX_LSB(0)) u_dut_a (
        .clk(clk), .rstN(rstN), .coef_we(coef_we[0]), .coef_addr(coef_addr[0]),
        .coef_data(coef_data[0]), .clear(clear[0]), .in_valid(in_valid[0]), .x(x[0]),
        .approx_en(approx_en[0]), .out_valid(out_valid[0]), .y(y[0])
    );

    fir_ntap_approx #(.DW(16), .CW(16), .NTAPS(5), .SHIFT(0), .APPROX_LSB(4)) u_dut_b (
        .clk(clk), .rstN(rstN), .coef_we(coef_we[1]), .coef_addr(coef_addr[1]),
        .coef_data(coef_data[1]), .clear(clear[1]), .in_valid(in_valid[1]), .x(x[1]),
        .approx_en(approx_en[1]), .out_valid(out_valid[1]), .y(y[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: sample history, coefficients and results waiting to emerge.
    int     ntaps [2] = '{8, 5};
    int     shf   [2] = '{15, 0};
    int     alsb  [2] = '{0, 4};
    longint hist  [2][8];
    longint coef  [2][8];
    bit     pv    [2][2];
    longint py    [2][2];
    bit     exp_ov[2];
    longint exp_y [2];
    longint oa[$];
    longint ob[$];

    int ca[8]  = '{-2000, 5000, 0, 123, -32768, 77, 9000, -1};
    int xs[12] = '{100, -200, 32767, -32768, 0, 5, 1234, -4321, 7, 7, -1, 20000};

    function automatic longint sat16(longint r);
        if (r > 32767)  return 32767;
        if (r < -32768) return -32768;
        return r;
    endfunction

    task automatic model_step(int i);
        longint acc;
        longint p;
        if (!rstN) begin
            for (int k = 0; k < 8; k++) begin
                hist[i][k] = 0;
                coef[i][k] = 0;
            end
            pv[i][0] = 0; pv[i][1] = 0;
            exp_ov[i] = 0; exp_y[i] = 0;
            return;
        end
        exp_ov[i] = pv[i][0];
        if (pv[i][0]) exp_y[i] = py[i][0];
        pv[i][0] = pv[i][1]; py[i][0] = py[i][1]; pv[i][1] = 0;
        if (clear[i]) begin
            pv[i][0] = 0;
            for (int k = 0; k < 8; k++) hist[i][k] = 0;
        end else if (in_valid[i]) begin
            for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = x[i];
            acc = 0;
            for (int k = 0; k < ntaps[i]; k++) begin
                p = hist[i][k] * coef[i][k];
                if (approx_en[i]) p = p & ~((64'sd1 <<< alsb[i]) - 1);
                acc += p;
            end
            pv[i][1] = 1;
            py[i][1] = sat16(acc >>> shf[i]);
        end
        if (coef_we[i] && (int'(coef_addr[i]) < ntaps[i])) coef[i][coef_addr[i]] = coef_data[i];
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    task automatic chk(string nm, logic signed [63:0] got, longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("out_valid%0d", i), {63'd0, out_valid[i]}, exp_ov[i]);
            chk($sformatf("y%0d", i), y[i], exp_y[i]);
        end
        if (out_valid[0]) oa.push_back(y[0]);
        if (out_valid[1]) ob.push_back(y[1]);
    end

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            coef_we[i] = 0; coef_addr[i] = '0; coef_data[i] = '0;
            clear[i] = 0; in_valid[i] = 0; x[i] = '0; approx_en[i] = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        idle_all();
    endtask

    task automatic gap(int n);
        repeat (n) tick();
    endtask

    task automatic send(int i, int xv, bit ap = 0);
        in_valid[i] = 1; x[i] = 16'(xv); approx_en[i] = ap;
        tick();
    endtask

    task automatic wcoef(int i, int a, int d);
        coef_we[i] = 1; coef_addr[i] = 3'(a); coef_data[i] = 16'(d);
        tick();
    endtask

    task automatic check_impulse(string tag);
        chk({tag, "_n"}, oa.size(), 8);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("%s_%0d", tag, j), (j < oa.size()) ? oa[j] : -1, 500 * (j + 1));
        end
    endtask

    initial begin
        idle_all();
        repeat (3) @(negedge clk);
        rstN = 1;
        tick();

        // Impulse response with back-to-back samples.
        for (int k = 0; k < 8; k++) wcoef(0, k, 1000 * (k + 1));
        oa.delete();
        send(0, 16384);
        for (int k = 0; k < 7; k++) send(0, 0);
        gap(4);
        check_impulse("imp");

        // Same impulse on a sparse stream.
        oa.delete();
        send(0, 16384); gap(2);
        for (int k = 0; k < 7; k++) begin send(0, 0); gap(2); end
        gap(3);
        check_impulse("sparse");

        // Saturation in both directions.
        for (int k = 0; k < 8; k++) wcoef(0, k, 32767);
        oa.delete();
        for (int k = 0; k < 10; k++) send(0, 32767);
        gap(4);
        chk("sat_pos", (oa.size() > 0) ? oa[$] : 0, 32767);
        oa.delete();
        for (int k = 0; k < 10; k++) send(0, -32768);
        gap(4);
        chk("sat_neg", (oa.size() > 0) ? oa[$] : 0, -32768);

        // Mixed-sign coefficients and samples, with occasional gaps.
        for (int k = 0; k < 8; k++) wcoef(0, k, ca[k]);
        for (int k = 0; k < 12; k++) begin
            send(0, xs[k]);
            if (k % 3 == 0) gap(1);
        end
        gap(4);

        // Approximate-product mode on the second instance.
        wcoef(1, 0, 3);
        ob.delete();
        send(1, 5, 0); send(1, 5, 1); send(1, -5, 0); send(1, -5, 1);
        gap(4);
        chk("apx_n", ob.size(), 4);
        chk("apx_p_exact", (ob.size() > 0) ? ob[0] : -99, 15);
        chk("apx_p_trunc", (ob.size() > 1) ? ob[1] : -99, 0);
        chk("apx_n_exact", (ob.size() > 2) ? ob[2] : -99, -15);
        chk("apx_n_trunc", (ob.size() > 3) ? ob[3] : -99, -16);

        // Coefficient write colliding with a sample, then an out-of-range write.
        ob.delete();
        coef_we[1] = 1; coef_addr[1] = 3'd0; coef_data[1] = 16'sd7;
        send(1, 5);
        send(1, 5);
        wcoef(1, 5, 100);
        send(1, 5);
        gap(4);
        chk("coll_old", (ob.size() > 0) ? ob[0] : -99, 15);
        chk("coll_new", (ob.size() > 1) ? ob[1] : -99, 35);
        chk("oor_ignored", (ob.size() > 2) ? ob[2] : -99, 35);

        // Reset while a sample is in flight.
        oa.delete();
        send(0, 1000);
        rstN = 0;
        gap(3);
        rstN = 1;
        tick();
        gap(3);
        chk("rst_nout", oa.size(), 0);
        chk("rst_y", y[0], 0);

        // Clear during streaming discards history and the newest in-flight sample.
        wcoef(0, 0, 1000);
        wcoef(0, 1, 1000);
        oa.delete();
        for (int k = 0; k < 4; k++) send(0, 16384);
        clear[0] = 1;
        send(0, 16384);
        send(0, 16384);
        gap(4);
        chk("clr_n", oa.size(), 4);
        chk("clr_pre", (oa.size() > 2) ? oa[2] : -99, 1000);
        chk("clr_post", (oa.size() > 0) ? oa[$] : -99, 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_ntap_approx.md
Name: fir_ntap_approx

Overview:
- Parametrised N-tap direct-form FIR filter. Next-generation replacement for the fixed 3-tap filter in the ECG approximate-computing datapath.
- Coefficients are loaded at run time, input/output carry a valid handshake, and there is a per-sample approximate-product mode for MSE studies.
- Sits between the sample source (file-driven bench or ADC front end) and the metric/output logger. Supports sparse input streams.

Parameters:
- DW, 16, signed sample width of x and y.
- CW, 16, signed coefficient width.
- NTAPS, 8, number of taps (2..32).
- SHIFT, 15, arithmetic right shift applied to the accumulator before saturation (Q-format scaling).
- APPROX_LSB, 0, number of product LSBs forced to 0 when approx_en=1 (0 = approx mode has no effect).
- AW, $clog2(NTAPS), coefficient address width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous active-low reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  tap index to write; index 0 multiplies the newest sample.
- coef_data  in  CW  signed coefficient value.
- clear  in  1  synchronous flush of delay line and pipeline valids.
- in_valid  in  1  x is a new sample this cycle.
- x  in  DW  signed input sample.
- approx_en  in  1  approximate mode for the sample accepted this cycle.
- out_valid  out  1  y holds a new result this cycle.
- y  out  DW  signed filtered output.

Behaviour:
- Reset (rstN=0, async): delay line, coefficient bank, pipeline registers, y, and out_valid all go to 0. Release is synchronous to clk.
- Delay line: shifts only on the clk edge where in_valid=1. d[0]<=x and d[k]<=d[k-1]. It holds when in_valid=0, so gaps do not insert zeros.
- Stage 1 (edge where in_valid=1): registers p[k]=d_next[k]*h[k] at full width DW+CW. d_next is the delay line including the new x. approx_en is captured alongside the products.
- Approx masking: if the captured approx_en=1, each p[k] has its low APPROX_LSB bits cleared (bitwise AND, two's complement). This truncates toward negative infinity.
- Stage 2: acc = sum of all p[k] at width DW+CW+clog2(NTAPS), so there is no overflow. Then r = acc >>> SHIFT (arithmetic).
- Saturation: y = r clamped to [-2^(DW-1), 2^(DW-1)-1].
- Timing: out_valid=1 exactly 2 cycles after the accepted in_valid edge, one pulse per accepted sample. Back-to-back in_valid gives back-to-back out_valid.
- y holds its last value while out_valid=0.
- Coefficient write: h[coef_addr]<=coef_data on the edge where coef_we=1. It affects samples accepted from the next edge on. If coef_we and in_valid fall on the same edge, that sample uses the old coefficient. Results already in the pipeline are unaffected.
- clear=1: zeroes the delay line and the stage-1/stage-2 valids on that edge. Coefficients are kept and y is not changed.
- clear has priority over in_valid on the same edge; that sample is dropped.
- Reset mid-stream: all in-flight results are discarded and no out_valid follows. Coefficients return to 0, so software must reload them.
- Write with coef_addr >= NTAPS (non-power-of-two NTAPS): ignored.

Test Plan:
1. Impulse response: NTAPS=8, SHIFT=15, h[k]=1000*(k+1). Send x=16384 then 7 zeros, all with in_valid=1 -> y sequence 500,1000,...,4000. Each value appears 2 cycles after its input.
2. Sparse stream with gaps: same setup, in_valid toggled 1,0,0,1,... -> same 8 output values, each 2 cycles after its accepted input. out_valid=0 during gaps and y held.
3. Saturation: all h=32767, x=32767 continuous -> y=32767 once the line is full. Then x=-32768 continuous -> y=-32768.
4. Approx mode: SHIFT=0, APPROX_LSB=4, only h[0]=3, x=5 -> y=15 with approx_en=0, y=0 with approx_en=1. Repeat with x=-5 -> y=-15 exact, y=-16 approx.
5. Coefficient write collision: coef_we h[0]:3->7 on the same edge as x=5 (SHIFT=0) -> y=15. The next sample x=5 -> y=35.
6. Reset/clear mid-stream: assert rstN=0 one cycle after in_valid -> no out_valid and y=0. After reload, clear during streaming -> next output equals h[0]*x>>>SHIFT, with no history contribution.
